// File: rtl/execute_alu_pipe.sv
// Pipelined RV integer ALU (OP / OP-IMM) for the execute stage.
// Valid/ready on both sides, global-enable pipeline of STAGES registers, synchronous flush.
module execute_alu_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [6:0]      decode_opcode,
    input  logic [2:0]      decode_funct3,
    input  logic [6:0]      decode_funct7,
    input  logic [XLEN-1:0] decode_imm,
    input  logic [XLEN-1:0] read_rs1_val,
    input  logic [XLEN-1:0] read_rs2_val,
    input  logic            read_valid,
    output logic            processing,
    output logic            read_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_val_out
);

    localparam int         SHW        = $clog2(XLEN);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_NONE
    } alu_op_e;

    alu_op_e         op_sel;
    logic            is_imm;
    logic            shamt_hi_ok;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            accept;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [XLEN-1:0]   data_q [STAGES];
    logic [XLEN-1:0]   data_d [STAGES];

    // An RV32 shift immediate with bit 5 set is an illegal encoding, not a wide shift.
    assign shamt_hi_ok = (XLEN == 64) || !decode_funct7[0];

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        op_sel = OP_NONE;
        is_imm = 1'b0;
        if (decode_opcode == OPC_OP) begin
            case ({decode_funct7, decode_funct3})
                10'b0000000_000: op_sel = OP_ADD;
                10'b0100000_000: op_sel = OP_SUB;
                10'b0000000_001: op_sel = OP_SLL;
                10'b0000000_010: op_sel = OP_SLT;
                10'b0000000_011: op_sel = OP_SLTU;
                10'b0000000_100: op_sel = OP_XOR;
                10'b0000000_101: op_sel = OP_SRL;
                10'b0100000_101: op_sel = OP_SRA;
                10'b0000000_110: op_sel = OP_OR;
                10'b0000000_111: op_sel = OP_AND;
                default:         op_sel = OP_NONE;
            endcase
        end else if (decode_opcode == OPC_OP_IMM) begin
            is_imm = 1'b1;
            case (decode_funct3)
                3'b000: op_sel = OP_ADD;
                3'b010: op_sel = OP_SLT;
                3'b011: op_sel = OP_SLTU;
                3'b100: op_sel = OP_XOR;
                3'b110: op_sel = OP_OR;
                3'b111: op_sel = OP_AND;
                3'b001: begin
                    if (decode_funct7[6:1] == 6'b000000 && shamt_hi_ok)
                        op_sel = OP_SLL;
                end
                3'b101: begin
                    if (shamt_hi_ok) begin
                        if (decode_funct7[6:1] == 6'b000000)
                            op_sel = OP_SRL;
                        else if (decode_funct7[6:1] == 6'b010000)
                            op_sel = OP_SRA;
                    end
                end
                default: op_sel = OP_NONE;
            endcase
        end
    end

    assign op_b  = is_imm ? decode_imm : read_rs2_val;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (op_sel)
            OP_ADD:  alu_res = read_rs1_val + op_b;
            OP_SUB:  alu_res = read_rs1_val - op_b;
            OP_SLL:  alu_res = read_rs1_val << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(read_rs1_val) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (read_rs1_val < op_b)};
            OP_XOR:  alu_res = read_rs1_val ^ op_b;
            OP_SRL:  alu_res = read_rs1_val >> shamt;
            OP_SRA:  alu_res = $signed(read_rs1_val) >>> shamt;
            OP_OR:   alu_res = read_rs1_val | op_b;
            OP_AND:  alu_res = read_rs1_val & op_b;
            default: alu_res = '0;
        endcase
    end

    assign processing = (op_sel != OP_NONE) && read_valid;
    assign read_ready = !valid_q[STAGES-1] || out_ready;
    assign accept     = processing && read_ready && !flush;

    // Global enable: all stages shift together; empty slots travel as bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (read_ready) begin
            valid_d[0] = accept;
            data_d[0]  = alu_res;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
        if (flush)
            valid_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // NOTE: only the visible output register is reset; inner data stages are qualified by valid bits.
    always_ff @(posedge clk) begin
        if (reset)
            data_q[STAGES-1] <= '0;
        else
            data_q <= data_d;
    end

    assign out_valid  = valid_q[STAGES-1];
    assign rd_val_out = data_q[STAGES-1];

endmodule

// File: tb/tb_execute_alu_pipe.sv
// Self-checking bench for execute_alu_pipe: directed vectors, stall, flush, mid-stream reset
// and a randomized stream scored against an arithmetic reference model.
module tb_execute_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Shared stimulus for the two 32-bit instances (A: STAGES=1, B: STAGES=3).
    logic        flush_s, rv_s, ordy_s;
    logic [6:0]  op_s, f7_s;
    logic [2:0]  f3_s;
    logic [31:0] imm_s, rs1_s, rs2_s;
    logic        proc_a, rrdy_a, ov_a, proc_b, rrdy_b, ov_b;
    logic [31:0] rd_a, rd_b;

    // 64-bit instance C: STAGES=2.
    logic        flush_c, rv_c, ordy_c;
    logic [6:0]  op_c, f7_c;
    logic [2:0]  f3_c;
    logic [63:0] imm_c, rs1_c, rs2_c, rd_c;
    logic        proc_c, rrdy_c, ov_c;

    int total = 0;
    int bad   = 0;

    execute_alu_pipe #(.XLEN(32), .STAGES(1)) u_a (
        .clk(clk), .reset(reset), .flush(flush_s),
        .decode_opcode(op_s), .decode_funct3(f3_s), .decode_funct7(f7_s), .decode_imm(imm_s),
        .read_rs1_val(rs1_s), .read_rs2_val(rs2_s), .read_valid(rv_s),
        .processing(proc_a), .read_ready(rrdy_a), .out_valid(ov_a), .out_ready(ordy_s),
        .rd_val_out(rd_a));

    execute_alu_pipe #(.XLEN(32), .STAGES(3)) u_b (
        .clk(clk), .reset(reset), .flush(flush_s),
        .decode_opcode(op_s), .decode_funct3(f3_s), .decode_funct7(f7_s), .decode_imm(imm_s),
        .read_rs1_val(rs1_s), .read_rs2_val(rs2_s), .read_valid(rv_s),
        .processing(proc_b), .read_ready(rrdy_b), .out_valid(ov_b), .out_ready(ordy_s),
        .rd_val_out(rd_b));

    execute_alu_pipe #(.XLEN(64), .STAGES(2)) u_c (
        .clk(clk), .reset(reset), .flush(flush_c),
        .decode_opcode(op_c), .decode_funct3(f3_c), .decode_funct7(f7_c), .decode_imm(imm_c),
        .read_rs1_val(rs1_c), .read_rs2_val(rs2_c), .read_valid(rv_c),
        .processing(proc_c), .read_ready(rrdy_c), .out_valid(ov_c), .out_ready(ordy_c),
        .rd_val_out(rd_c));

    // Reference: {known, result}. Shifts are done as multiply/divide by 2**shamt.
    function automatic logic [64:0] model(input int xlen, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [63:0] a_in, input logic [63:0] rs2,
                                          input logic [63:0] imm);
        logic [63:0] mask, msb, a, b, p2, r, sra;
        int          sh;
        logic        known;
        mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        msb   = 64'd1 << (xlen - 1);
        a     = a_in & mask;
        b     = ((op == 7'h13) ? imm : rs2) & mask;
        sh    = int'(b % 64'(xlen));
        p2    = 64'd1 << sh;
        sra   = ((a & msb) != 64'd0) ? ~((~a & mask) / p2) : (a / p2);
        known = 1'b1;
        r     = 64'd0;
        if (op == 7'h33) begin
            case ({f7, f3})
                {7'h00, 3'd0}: r = a + b;
                {7'h20, 3'd0}: r = a - b;
                {7'h00, 3'd1}: r = a * p2;
                {7'h00, 3'd2}: r = {63'd0, ((a ^ msb) < (b ^ msb))};
                {7'h00, 3'd3}: r = {63'd0, (a < b)};
                {7'h00, 3'd4}: r = a ^ b;
                {7'h00, 3'd5}: r = a / p2;
                {7'h20, 3'd5}: r = sra;
                {7'h00, 3'd6}: r = a | b;
                {7'h00, 3'd7}: r = a & b;
                default:       known = 1'b0;
            endcase
        end else if (op == 7'h13) begin
            case (f3)
                3'd0: r = a + b;
                3'd2: r = {63'd0, ((a ^ msb) < (b ^ msb))};
                3'd3: r = {63'd0, (a < b)};
                3'd4: r = a ^ b;
                3'd6: r = a | b;
                3'd7: r = a & b;
                3'd1: begin
                    if (f7[6:1] == 6'd0 && (xlen == 64 || !f7[0])) r = a * p2;
                    else known = 1'b0;
                end
                default: begin
                    if (xlen == 32 && f7[0])            known = 1'b0;
                    else if (f7[6:1] == 6'b000000)      r = a / p2;
                    else if (f7[6:1] == 6'b010000)      r = sra;
                    else                                known = 1'b0;
                end
            endcase
        end else begin
            known = 1'b0;
        end
        return {known, r & mask};
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, imm, exp;
        logic        known;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] exp, input logic known);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.imm = imm; v.exp = exp; v.known = known;
        return v;
    endfunction

    function automatic vec_t get_vec(input int k);
        case (k)
            0:  return mk(7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd1,  32'd0, 32'h0000_0000, 1'b1); // ADD wrap
            1:  return mk(7'h33, 3'd0, 7'h20, 32'd5, 32'd7,         32'd0, 32'hFFFF_FFFE, 1'b1); // SUB
            2:  return mk(7'h33, 3'd2, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 32'd1, 1'b1);         // SLT
            3:  return mk(7'h33, 3'd3, 7'h00, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b1);         // SLTU
            4:  return mk(7'h13, 3'd3, 7'h7F, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);         // SLTIU
            5:  return mk(7'h13, 3'd5, 7'h20, 32'h8000_0010, 32'd0, 32'h404, 32'hF800_0001, 1'b1); // SRAI
            6:  return mk(7'h33, 3'd5, 7'h00, 32'h8000_0010, 32'h24, 32'd0, 32'h0800_0001, 1'b1); // SRL
            7:  return mk(7'h13, 3'd1, 7'h01, 32'd1, 32'd0, 32'h21, 32'd0, 1'b0);                // SLLI bad
            8:  return mk(7'h13, 3'd4, 7'h7F, 32'h0000_F0F0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_0F0F, 1'b1);
            9:  return mk(7'h33, 3'd0, 7'h01, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);                 // bad funct7
            10: return mk(7'h13, 3'd1, 7'h00, 32'd1, 32'd0, 32'h1F, 32'h8000_0000, 1'b1);        // SLLI 31
            11: return mk(7'h13, 3'd5, 7'h21, 32'hF000_0000, 32'd0, 32'h424, 32'd0, 1'b0);      // SRAI rv32 bad
            default: return mk(7'h03, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0);            // other opcode
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rv_s = 1'b0; flush_s = 1'b0; ordy_s = 1'b1; rv_c = 1'b0; ordy_c = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ov_a !== 1'b0 || ov_b !== 1'b0 || ov_c !== 1'b0)
            begin bad++; $display("FAIL reset_valid: got a=%b b=%b c=%b want 0", ov_a, ov_b, ov_c); end
        total++;
        if (rd_a !== 32'd0 || rd_b !== 32'd0 || rd_c !== 64'd0)
            begin bad++; $display("FAIL reset_data: got a=%h b=%h c=%h want 0", rd_a, rd_b, rd_c); end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ov_a !== 1'b0 || ov_b !== 1'b0 || ov_c !== 1'b0)
            begin bad++; $display("FAIL post_reset_valid: got a=%b b=%b c=%b want 0", ov_a, ov_b, ov_c); end
    endtask

    // Back-to-back directed vectors on the STAGES=1 instance: each result is due one cycle later.
    task automatic test_vectors();
        vec_t        v;
        logic [31:0] prev_exp = 32'd0;
        logic        prev_known = 1'b0;
        int          n = 13;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k > 0) begin
                total++;
                if (ov_a !== prev_known)
                    begin bad++; $display("FAIL vec%0d_valid: got %b want %b", k-1, ov_a, prev_known); end
                if (prev_known) begin
                    total++;
                    if (rd_a !== prev_exp)
                        begin bad++; $display("FAIL vec%0d_result: got %h want %h", k-1, rd_a, prev_exp); end
                end
            end
            if (k < n) begin
                v = get_vec(k);
                op_s = v.op; f3_s = v.f3; f7_s = v.f7; rs1_s = v.a; rs2_s = v.b; imm_s = v.imm;
                rv_s = 1'b1; ordy_s = 1'b1; flush_s = 1'b0;
                #1;
                total++;
                if (proc_a !== v.known)
                    begin bad++; $display("FAIL vec%0d_processing: got %b want %b", k, proc_a, v.known); end
                prev_known = v.known;
                prev_exp   = v.exp;
            end else begin
                rv_s = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] a_v [4];
        logic [31:0] b_v [4];
        int issued = 0;
        int got = 0;
        for (int i = 0; i < 4; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            ordy_s = (c == 0) || (c >= 7);
            flush_s = 1'b0;
            if (issued < 4) begin
                op_s = 7'h33; f3_s = 3'd0; f7_s = 7'h00; rs1_s = a_v[issued]; rs2_s = b_v[issued];
                rv_s = 1'b1;
            end else begin
                rv_s = 1'b0;
            end
            #1;
            if (c >= 3 && c < 7) begin
                total++;
                if (rrdy_b !== 1'b0 || ov_b !== 1'b1 || rd_b !== a_v[0] + b_v[0])
                    begin bad++; $display("FAIL stall_hold c%0d: got ready=%b valid=%b data=%h want 0 1 %h",
                                          c, rrdy_b, ov_b, rd_b, a_v[0] + b_v[0]); end
            end
            if (ov_b && ordy_s) begin
                total++;
                if (got >= 4)
                    begin bad++; $display("FAIL stall_extra: got result %h want none", rd_b); end
                else if (rd_b !== a_v[got] + b_v[got])
                    begin bad++; $display("FAIL stall_order%0d: got %h want %h", got, rd_b, a_v[got] + b_v[got]); end
                got++;
            end
            if (rv_s && rrdy_b) issued++;
        end
        total++;
        if (got != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", got); end
    endtask

    task automatic test_flush();
        logic [31:0] a_v [4];
        logic [31:0] b_v [4];
        logic        exp_ov [5];
        exp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                total++;
                if (ov_b !== exp_ov[c-3])
                    begin bad++; $display("FAIL flush_valid c%0d: got %b want %b (data %h)", c, ov_b, exp_ov[c-3], rd_b); end
                if (exp_ov[c-3]) begin
                    total++;
                    if (rd_b !== a_v[3] + b_v[3])
                        begin bad++; $display("FAIL flush_next_op: got %h want %h", rd_b, a_v[3] + b_v[3]); end
                end
            end
            ordy_s = 1'b1;
            flush_s = (c == 2);
            op_s = 7'h33; f3_s = 3'd0; f7_s = 7'h00;
            if (c <= 3) begin
                rs1_s = a_v[c]; rs2_s = b_v[c]; rv_s = 1'b1;
            end else begin
                rv_s = 1'b0;
            end
        end
        flush_s = 1'b0;
    endtask

    task automatic test_reset_mid_64();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            case (c)
                0: begin
                    op_c = 7'h33; f3_c = 3'd5; f7_c = 7'h20; rs1_c = 64'h8000_0000_0000_0000;
                    rs2_c = 64'd63; imm_c = 64'd0; rv_c = 1'b1; ordy_c = 1'b1;
                    #1; total++;
                    if (proc_c !== 1'b1) begin bad++; $display("FAIL sra64_processing: got %b want 1", proc_c); end
                end
                1: begin
                    op_c = 7'h13; f3_c = 3'd1; f7_c = 7'h01; rs1_c = 64'd1; imm_c = 64'h20; ordy_c = 1'b0;
                    #1; total++;
                    if (proc_c !== 1'b1) begin bad++; $display("FAIL slli64_processing: got %b want 1", proc_c); end
                end
                2: begin
                    total++;
                    if (ov_c !== 1'b1 || rd_c !== 64'hFFFF_FFFF_FFFF_FFFF)
                        begin bad++; $display("FAIL sra64_result: got %b %h want 1 ffffffffffffffff", ov_c, rd_c); end
                    reset = 1'b1; op_c = 7'h33; f3_c = 3'd0; f7_c = 7'h00; rs2_c = 64'd9;
                end
                3: begin
                    total++;
                    if (ov_c !== 1'b0 || rd_c !== 64'd0)
                        begin bad++; $display("FAIL reset_mid: got %b %h want 0 0", ov_c, rd_c); end
                    reset = 1'b0; op_c = 7'h13; f3_c = 3'd1; f7_c = 7'h01; rs1_c = 64'd1; imm_c = 64'h20;
                    rv_c = 1'b1; ordy_c = 1'b1;
                end
                4: begin
                    total++;
                    if (ov_c !== 1'b0) begin bad++; $display("FAIL slli64_early: got %b want 0", ov_c); end
                    rv_c = 1'b0;
                end
                5: begin
                    total++;
                    if (ov_c !== 1'b1 || rd_c !== 64'h0000_0001_0000_0000)
                        begin bad++; $display("FAIL slli64_result: got %b %h want 1 100000000", ov_c, rd_c); end
                end
                default: begin
                    total++;
                    if (ov_c !== 1'b0) begin bad++; $display("FAIL slli64_dup: got %b want 0", ov_c); end
                end
            endcase
        end
        rv_c = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [64:0] m;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op_s = 7'h33;
                5, 6, 7, 8:    op_s = 7'h13;
                default:       op_s = 7'($urandom);
            endcase
            f3_s = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       f7_s = 7'h00;
                1:       f7_s = 7'h20;
                2:       f7_s = 7'h01;
                default: f7_s = 7'($urandom);
            endcase
            rs1_s = pick_val(); rs2_s = pick_val(); imm_s = pick_val();
            rv_s = ($urandom_range(0, 3) != 0);
            ordy_s = ($urandom_range(0, 3) != 0);
            flush_s = ($urandom_range(0, 29) == 0);
            #1;
            m = model(32, op_s, f3_s, f7_s, {32'd0, rs1_s}, {32'd0, rs2_s}, {32'd0, imm_s});
            total++;
            if (proc_b !== (m[64] & rv_s))
                begin bad++; $display("FAIL rnd_processing c%0d: got %b want %b", cyc, proc_b, m[64] & rv_s); end
            total++;
            if (rrdy_b !== (!ov_b || ordy_s))
                begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, rrdy_b, !ov_b || ordy_s); end
            if (ov_b && ordy_s) begin
                total++;
                if (exp_q.size() == 0)
                    begin bad++; $display("FAIL rnd_unexpected c%0d: got %h want none", cyc, rd_b); end
                else begin
                    if (rd_b !== exp_q[0])
                        begin bad++; $display("FAIL rnd_result c%0d: got %h want %h", cyc, rd_b, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (flush_s) exp_q.delete();
            else if (m[64] && rv_s && rrdy_b) exp_q.push_back(m[31:0]);
        end
        rv_s = 1'b0; flush_s = 1'b0; ordy_s = 1'b1;
        for (int d = 0; d < 20; d++) begin
            @(negedge clk);
            #1;
            if (ov_b) begin
                total++;
                if (exp_q.size() == 0)
                    begin bad++; $display("FAIL drain_unexpected: got %h want none", rd_b); end
                else begin
                    if (rd_b !== exp_q[0])
                        begin bad++; $display("FAIL drain_result: got %h want %h", rd_b, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (!ov_b && exp_q.size() == 0) break;
        end
        total++;
        if (exp_q.size() != 0 || ov_b !== 1'b0)
            begin bad++; $display("FAIL drain_left: got %0d pending valid=%b want 0", exp_q.size(), ov_b); end
    endtask

    initial begin
        reset = 1'b1;
        flush_s = 1'b0; rv_s = 1'b0; ordy_s = 1'b1;
        op_s = 7'h00; f3_s = 3'd0; f7_s = 7'h00; imm_s = 32'd0; rs1_s = 32'd0; rs2_s = 32'd0;
        flush_c = 1'b0; rv_c = 1'b0; ordy_c = 1'b1;
        op_c = 7'h00; f3_c = 3'd0; f7_c = 7'h00; imm_c = 64'd0; rs1_c = 64'd0; rs2_c = 64'd0;
        test_reset();
        test_vectors();
        idle(5);
        test_back_to_back_stall();
        idle(5);
        test_flush();
        idle(5);
        test_reset_mid_64();
        idle(3);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
